// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline register with stall/flush control for the hazard unit,
// a saturating bubble counter for performance debug, and load-in-EX status.
module id_ex_pipe_reg #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             flush,
  input  logic             valid_d,
  input  logic             reg_write_d,
  input  logic             alu_src_d,
  input  logic             mem_write_d,
  input  logic [1:0]       result_src_d,
  input  logic [2:0]       alu_control_d,
  input  logic             lui_d,
  input  logic             jump_d,
  input  logic             jalr_d,
  input  logic             branch_d,
  input  logic [2:0]       funct3_d,
  input  logic [XLEN-1:0]  rd1_d,
  input  logic [XLEN-1:0]  rd2_d,
  input  logic [XLEN-1:0]  pc_d,
  input  logic [XLEN-1:0]  pc_plus4_d,
  input  logic [XLEN-1:0]  imm_ext_d,
  input  logic [4:0]       rs1_d,
  input  logic [4:0]       rs2_d,
  input  logic [4:0]       rd_d,
  output logic             valid_e,
  output logic             reg_write_e,
  output logic             alu_src_e,
  output logic             mem_write_e,
  output logic [1:0]       result_src_e,
  output logic [2:0]       alu_control_e,
  output logic             lui_e,
  output logic             jump_e,
  output logic             jalr_e,
  output logic             branch_e,
  output logic [2:0]       funct3_e,
  output logic [XLEN-1:0]  rd1_e,
  output logic [XLEN-1:0]  rd2_e,
  output logic [XLEN-1:0]  pc_e,
  output logic [XLEN-1:0]  pc_plus4_e,
  output logic [XLEN-1:0]  imm_ext_e,
  output logic [4:0]       rs1_e,
  output logic [4:0]       rs2_e,
  output logic [4:0]       rd_e,
  output logic             load_e,
  output logic [CNT_W-1:0] bubble_count
);

  logic             valid_reg,       valid_next;
  logic             reg_write_reg,   reg_write_next;
  logic             alu_src_reg,     alu_src_next;
  logic             mem_write_reg,   mem_write_next;
  logic [1:0]       result_src_reg,  result_src_next;
  logic [2:0]       alu_control_reg, alu_control_next;
  logic             lui_reg,         lui_next;
  logic             jump_reg,        jump_next;
  logic             jalr_reg,        jalr_next;
  logic             branch_reg,      branch_next;
  logic [2:0]       funct3_reg,      funct3_next;
  logic [XLEN-1:0]  rd1_reg,         rd1_next;
  logic [XLEN-1:0]  rd2_reg,         rd2_next;
  logic [XLEN-1:0]  pc_reg,          pc_next;
  logic [XLEN-1:0]  pc_plus4_reg,    pc_plus4_next;
  logic [XLEN-1:0]  imm_ext_reg,     imm_ext_next;
  logic [4:0]       rs1_reg,         rs1_next;
  logic [4:0]       rs2_reg,         rs2_next;
  logic [4:0]       rd_reg,          rd_next;
  logic [CNT_W-1:0] count_reg,       count_next;
  logic             bubble_inc;

  // Next-state selection: flush inserts an all-zero NOP, stall holds, else capture qualified inputs
  always_comb begin
    valid_next       = valid_reg;
    reg_write_next   = reg_write_reg;
    alu_src_next     = alu_src_reg;
    mem_write_next   = mem_write_reg;
    result_src_next  = result_src_reg;
    alu_control_next = alu_control_reg;
    lui_next         = lui_reg;
    jump_next        = jump_reg;
    jalr_next        = jalr_reg;
    branch_next      = branch_reg;
    funct3_next      = funct3_reg;
    rd1_next         = rd1_reg;
    rd2_next         = rd2_reg;
    pc_next          = pc_reg;
    pc_plus4_next    = pc_plus4_reg;
    imm_ext_next     = imm_ext_reg;
    rs1_next         = rs1_reg;
    rs2_next         = rs2_reg;
    rd_next          = rd_reg;
    bubble_inc       = 1'b0;

    if (flush) begin
      // Flush overrides stall; data fields are zeroed too so the bubble is canonical
      valid_next       = 1'b0;
      reg_write_next   = 1'b0;
      alu_src_next     = 1'b0;
      mem_write_next   = 1'b0;
      result_src_next  = 2'b00;
      alu_control_next = 3'b000;
      lui_next         = 1'b0;
      jump_next        = 1'b0;
      jalr_next        = 1'b0;
      branch_next      = 1'b0;
      funct3_next      = 3'b000;
      rd1_next         = '0;
      rd2_next         = '0;
      pc_next          = '0;
      pc_plus4_next    = '0;
      imm_ext_next     = '0;
      rs1_next         = 5'd0;
      rs2_next         = 5'd0;
      rd_next          = 5'd0;
      bubble_inc       = 1'b1;
    end else if (!stall) begin
      valid_next       = valid_d;
      // Writes to x0 are dropped here so forwarding never sees them as producers
      reg_write_next   = reg_write_d & valid_d & (rd_d != 5'd0);
      alu_src_next     = alu_src_d;
      mem_write_next   = mem_write_d & valid_d;
      result_src_next  = result_src_d;
      alu_control_next = alu_control_d;
      lui_next         = lui_d;
      jump_next        = jump_d & valid_d;
      jalr_next        = jalr_d & valid_d;
      branch_next      = branch_d & valid_d;
      funct3_next      = funct3_d;
      rd1_next         = rd1_d;
      rd2_next         = rd2_d;
      pc_next          = pc_d;
      pc_plus4_next    = pc_plus4_d;
      imm_ext_next     = imm_ext_d;
      rs1_next         = rs1_d;
      rs2_next         = rs2_d;
      rd_next          = rd_d;
      // An empty decode slot moving into EX is also a bubble
      bubble_inc       = ~valid_d;
    end

    count_next = count_reg;
    if (bubble_inc && (count_reg != {CNT_W{1'b1}}))
      count_next = count_reg + CNT_W'(1);
  end

  // State register with synchronous reset to the all-zero NOP
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_reg       <= 1'b0;
      reg_write_reg   <= 1'b0;
      alu_src_reg     <= 1'b0;
      mem_write_reg   <= 1'b0;
      result_src_reg  <= 2'b00;
      alu_control_reg <= 3'b000;
      lui_reg         <= 1'b0;
      jump_reg        <= 1'b0;
      jalr_reg        <= 1'b0;
      branch_reg      <= 1'b0;
      funct3_reg      <= 3'b000;
      rd1_reg         <= '0;
      rd2_reg         <= '0;
      pc_reg          <= '0;
      pc_plus4_reg    <= '0;
      imm_ext_reg     <= '0;
      rs1_reg         <= 5'd0;
      rs2_reg         <= 5'd0;
      rd_reg          <= 5'd0;
      count_reg       <= '0;
    end else begin
      valid_reg       <= valid_next;
      reg_write_reg   <= reg_write_next;
      alu_src_reg     <= alu_src_next;
      mem_write_reg   <= mem_write_next;
      result_src_reg  <= result_src_next;
      alu_control_reg <= alu_control_next;
      lui_reg         <= lui_next;
      jump_reg        <= jump_next;
      jalr_reg        <= jalr_next;
      branch_reg      <= branch_next;
      funct3_reg      <= funct3_next;
      rd1_reg         <= rd1_next;
      rd2_reg         <= rd2_next;
      pc_reg          <= pc_next;
      pc_plus4_reg    <= pc_plus4_next;
      imm_ext_reg     <= imm_ext_next;
      rs1_reg         <= rs1_next;
      rs2_reg         <= rs2_next;
      rd_reg          <= rd_next;
      count_reg       <= count_next;
    end
  end

  assign valid_e       = valid_reg;
  assign reg_write_e   = reg_write_reg;
  assign alu_src_e     = alu_src_reg;
  assign mem_write_e   = mem_write_reg;
  assign result_src_e  = result_src_reg;
  assign alu_control_e = alu_control_reg;
  assign lui_e         = lui_reg;
  assign jump_e        = jump_reg;
  assign jalr_e        = jalr_reg;
  assign branch_e      = branch_reg;
  assign funct3_e      = funct3_reg;
  assign rd1_e         = rd1_reg;
  assign rd2_e         = rd2_reg;
  assign pc_e          = pc_reg;
  assign pc_plus4_e    = pc_plus4_reg;
  assign imm_ext_e     = imm_ext_reg;
  assign rs1_e         = rs1_reg;
  assign rs2_e         = rs2_reg;
  assign rd_e          = rd_reg;
  assign bubble_count  = count_reg;

  // Load-in-EX flag for load-use detection, derived only from registered state
  assign load_e = valid_reg & (result_src_reg == 2'b01);

endmodule
